// File: rtl/bist_pattern_misr.sv
// BIST harness: Galois-LFSR pattern source for a combinational netlist plus a
// Galois MISR that compacts the netlist responses into a signature for a golden compare.
module bist_pattern_misr #(
   parameter int                    PI_WIDTH      = 13,
   parameter int                    PO_WIDTH      = 23,
   parameter int                    PATTERN_COUNT = 256,
   parameter int                    RESP_LATENCY  = 0,
   parameter logic [PI_WIDTH-1:0]   LFSR_POLY     = 13'h100D,
   parameter logic [PI_WIDTH-1:0]   LFSR_SEED     = 13'h0001,
   parameter logic [PO_WIDTH-1:0]   MISR_POLY     = 23'h400021,
   parameter logic [PO_WIDTH-1:0]   MISR_SEED     = 23'h000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [PO_WIDTH-1:0] golden_sig,
   input  logic [PO_WIDTH-1:0] response_in,
   output logic [PI_WIDTH-1:0] pattern_out,
   output logic                pattern_valid,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [PO_WIDTH-1:0] signature,
   output logic [15:0]         pattern_idx
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_e;

   localparam logic [PI_WIDTH-1:0] LFSR_ONE  = {{(PI_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PI_WIDTH-1:0] SEED_EFF  = (LFSR_SEED == '0) ? LFSR_ONE : LFSR_SEED;
   localparam logic [15:0]         PC_LAST   = 16'(PATTERN_COUNT);
   localparam logic [15:0]         FLUSH_LAST = 16'(RESP_LATENCY - 1);

   state_e              state_q, state_d;
   logic [PI_WIDTH-1:0] pattern_q, pattern_d;
   logic                valid_q, valid_d;
   logic [15:0]         idx_q, idx_d;
   logic [PO_WIDTH-1:0] sig_q, sig_d;
   logic                pass_q, pass_d;
   logic                done_q, done_d;
   logic [15:0]         flush_cnt_q, flush_cnt_d;

   logic [PI_WIDTH-1:0] lfsr_nxt;
   logic [PO_WIDTH-1:0] misr_nxt;
   logic                cap_valid;
   logic                capture;

   // Response-side copy of pattern_valid, delayed to line up with the netlist path.
   if (RESP_LATENCY == 0) begin : g_nodly
      assign cap_valid = valid_q;
   end else begin : g_dly
      logic [RESP_LATENCY-1:0] vdly_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vdly_q <= '0;
         end else if (state_q == ST_IDLE) begin
            // Flushes stale valids left behind by an abort before the next run starts.
            vdly_q <= '0;
         end else begin
            vdly_q <= (vdly_q << 1) | RESP_LATENCY'(valid_q);
         end
      end
      assign cap_valid = vdly_q[RESP_LATENCY-1];
   end

   assign capture = cap_valid && (state_q == ST_RUN || state_q == ST_FLUSH);

   always_comb begin
      lfsr_nxt = pattern_q[0] ? ((pattern_q >> 1) ^ LFSR_POLY) : (pattern_q >> 1);
      if (lfsr_nxt == '0) lfsr_nxt = LFSR_ONE;
      misr_nxt = (sig_q[0] ? ((sig_q >> 1) ^ MISR_POLY) : (sig_q >> 1)) ^ response_in;
   end

   // NOTE: every next-state signal gets its hold value first so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      pattern_d   = pattern_q;
      valid_d     = valid_q;
      idx_d       = idx_q;
      sig_d       = sig_q;
      pass_d      = pass_q;
      done_d      = 1'b0;
      flush_cnt_d = flush_cnt_q;

      if (capture) sig_d = misr_nxt;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_RUN;
               pattern_d = SEED_EFF;
               valid_d   = 1'b1;
               idx_d     = 16'd1;
               sig_d     = MISR_SEED;
               pass_d    = 1'b0;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d   = ST_IDLE;
               valid_d   = 1'b0;
               pattern_d = '0;
               pass_d    = 1'b0;
            end else if (idx_q == PC_LAST) begin
               valid_d     = 1'b0;
               pattern_d   = '0;
               flush_cnt_d = '0;
               state_d     = (RESP_LATENCY > 0) ? ST_FLUSH : ST_DONE;
            end else begin
               pattern_d = lfsr_nxt;
               idx_d     = idx_q + 16'd1;
            end
         end
         ST_FLUSH: begin
            if (abort) begin
               state_d   = ST_IDLE;
               valid_d   = 1'b0;
               pattern_d = '0;
               pass_d    = 1'b0;
            end else if (flush_cnt_q == FLUSH_LAST) begin
               state_d = ST_DONE;
            end else begin
               flush_cnt_d = flush_cnt_q + 16'd1;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            pass_d  = (sig_q == golden_sig);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pattern_q   <= '0;
         valid_q     <= 1'b0;
         idx_q       <= '0;
         sig_q       <= MISR_SEED;
         pass_q      <= 1'b0;
         done_q      <= 1'b0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pattern_q   <= pattern_d;
         valid_q     <= valid_d;
         idx_q       <= idx_d;
         sig_q       <= sig_d;
         pass_q      <= pass_d;
         done_q      <= done_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign pattern_out   = pattern_q;
   assign pattern_valid = valid_q;
   assign busy          = (state_q == ST_RUN) || (state_q == ST_FLUSH);
   assign done          = done_q;
   assign pass          = pass_q;
   assign signature     = sig_q;
   assign pattern_idx   = idx_q;

endmodule

// File: tb/tb_bist_pattern_misr.sv
// Bench for bist_pattern_misr: four instances (default, 1 and 2 patterns, latency 3)
// checked against a pattern scoreboard and a reference signature model.
module tb_bist_pattern_misr;

   localparam int N = 4;

   function automatic int pc_of(input int k);
      case (k)
         0: return 256;
         1: return 1;
         2: return 2;
         default: return 4;
      endcase
   endfunction

   function automatic int lat_of(input int k);
      return (k == 3) ? 3 : 0;
   endfunction

   logic        clk;
   logic        rst_n;
   logic        start_s  [N];
   logic        abort_s  [N];
   logic [22:0] golden_s [N];
   logic [22:0] resp_s   [N];
   logic [12:0] pat_s    [N];
   logic        pv_s     [N];
   logic        busy_s   [N];
   logic        done_s   [N];
   logic        pass_s   [N];
   logic [22:0] sig_s    [N];
   logic [15:0] idx_s    [N];

   int n_tests = 0;
   int n_fail  = 0;
   logic [12:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      logic [12:0] p1, p2, p3;
      always @(posedge clk) begin
         p1 <= pat_s[g];
         p2 <= p1;
         p3 <= p2;
      end
      // Instance 0 sees its own pattern, 3 a 3-cycle pipelined copy, 1 and 2 a constant 1.
      assign resp_s[g] = (g == 0) ? {10'b0, pat_s[g]} :
                         (g == 3) ? {10'b0, p3} : 23'h000001;

      bist_pattern_misr #(
         .PATTERN_COUNT(pc_of(g)),
         .RESP_LATENCY (lat_of(g))
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .start        (start_s[g]),
         .abort        (abort_s[g]),
         .golden_sig   (golden_s[g]),
         .response_in  (resp_s[g]),
         .pattern_out  (pat_s[g]),
         .pattern_valid(pv_s[g]),
         .busy         (busy_s[g]),
         .done         (done_s[g]),
         .pass         (pass_s[g]),
         .signature    (sig_s[g]),
         .pattern_idx  (idx_s[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [12:0] lfsr_step(input logic [12:0] c);
      logic [12:0] n;
      n = c[0] ? ((c >> 1) ^ 13'h100D) : (c >> 1);
      if (n == 13'h0) n = 13'h0001;
      return n;
   endfunction

   function automatic logic [22:0] misr_step(input logic [22:0] s, input logic [22:0] r);
      return (s[0] ? ((s >> 1) ^ 23'h400021) : (s >> 1)) ^ r;
   endfunction

   task automatic reset_chk(input int k);
      check("rst_pattern", 32'(pat_s[k]), 0);
      check("rst_valid",   32'(pv_s[k]),  0);
      check("rst_busy",    32'(busy_s[k]), 0);
      check("rst_done",    32'(done_s[k]), 0);
      check("rst_pass",    32'(pass_s[k]), 0);
      check("rst_sig",     32'(sig_s[k]),  0);
      check("rst_idx",     32'(idx_s[k]),  0);
   endtask

   // Runs one start on instance k; optionally aborts at pattern_idx==abort_at
   // or re-pulses start while busy at sample extra_at.
   task automatic run_one(input int k, input int abort_at, input int extra_at);
      int pc, lat, vcnt, bcnt, dcnt, done_at, lim, dsum;
      logic [12:0] p, got_p;
      logic [22:0] es, gold;
      logic        ep;
      pc = pc_of(k);
      lat = lat_of(k);
      exp_q.delete();
      p  = 13'h0001;
      es = 23'h0;
      for (int i = 0; i < pc; i++) begin
         exp_q.push_back(p);
         es = misr_step(es, (k == 1 || k == 2) ? 23'h000001 : {10'b0, p});
         p  = lfsr_step(p);
      end
      gold = (k == 1) ? 23'h000001 : (k == 2) ? 23'h400021 : es;
      ep   = (es == gold);
      golden_s[k] = gold;
      vcnt = 0; bcnt = 0; dcnt = 0; done_at = -1;
      lim  = pc + lat + 6;

      step();
      start_s[k] = 1'b1;
      step();
      for (int e = 0; e < lim; e++) begin
         start_s[k] = 1'b0;
         if (e == 0) begin
            check("start_sig",  32'(sig_s[k]),  0);
            check("start_idx",  32'(idx_s[k]),  1);
            check("start_pass", 32'(pass_s[k]), 0);
         end
         if (pv_s[k]) begin
            if (exp_q.size() == 0) begin
               check("extra_pattern", 32'(pat_s[k]), 0);
            end else begin
               got_p = exp_q.pop_front();
               check("pattern", 32'(pat_s[k]), 32'(got_p));
               check("idx", 32'(idx_s[k]), 32'(vcnt + 1));
            end
            vcnt++;
         end
         if (busy_s[k]) bcnt++;
         if (done_s[k]) begin
            dcnt++;
            done_at = e;
            check("pass_at_done", 32'(pass_s[k]), 32'(ep));
         end
         if (abort_at > 0 && busy_s[k] && idx_s[k] == 16'(abort_at)) begin
            abort_s[k] = 1'b1;
            step();
            abort_s[k] = 1'b0;
            check("abort_busy",    32'(busy_s[k]), 0);
            check("abort_valid",   32'(pv_s[k]),   0);
            check("abort_pattern", 32'(pat_s[k]),  0);
            check("abort_pass",    32'(pass_s[k]), 0);
            dsum = 32'(done_s[k]);
            for (int j = 0; j < 8; j++) begin
               step();
               dsum += 32'(done_s[k]);
            end
            check("abort_no_done", 32'(dsum), 0);
            exp_q.delete();
            return;
         end
         if (e == extra_at) start_s[k] = 1'b1;
         step();
      end
      start_s[k] = 1'b0;
      check("valid_cycles", 32'(vcnt), 32'(pc));
      check("busy_cycles",  32'(bcnt), 32'(pc + lat));
      check("done_latency", 32'(done_at), 32'(pc + lat + 1));
      check("done_pulses",  32'(dcnt), 1);
      check("final_sig",    32'(sig_s[k]), 32'(es));
      check("final_pass",   32'(pass_s[k]), 32'(ep));
      check("final_busy",   32'(busy_s[k]), 0);
      check("final_idx",    32'(idx_s[k]), 32'(pc));
      check("queue_empty",  32'(exp_q.size()), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < N; k++) begin
         start_s[k]  = 1'b0;
         abort_s[k]  = 1'b0;
         golden_s[k] = 23'h0;
      end
      #7;
      for (int k = 0; k < N; k++) reset_chk(k);
      #5 rst_n = 1'b1;

      run_one(0, 0, -1);
      check("dut0_pass_default", 32'(pass_s[0]), 1);
      run_one(1, 0, -1);
      check("pc1_sig", 32'(sig_s[1]), 32'h000001);
      run_one(2, 0, -1);
      check("pc2_sig", 32'(sig_s[2]), 32'h400020);
      run_one(3, 0, -1);

      // Asynchronous reset in the middle of a run.
      step();
      start_s[0] = 1'b1;
      step();
      start_s[0] = 1'b0;
      repeat (30) step();
      check("midrun_busy", 32'(busy_s[0]), 1);
      rst_n = 1'b0;
      #1;
      reset_chk(0);
      step();
      #2 rst_n = 1'b1;

      run_one(0, 0, 20);
      run_one(0, 10, -1);
      run_one(0, 0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
